// File: rtl/protein_assay_dispense_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | protein_assay_dispense_seq: layer-by-layer valve/pump dispense sequencer  |
// | Optional pump watchdog: PROTEIN_SEQ_TIMEOUT_EN.   Revision: 1.0           |
// +--------------------------------------------------------------------------+
module protein_assay_dispense_seq #(
   parameter int SETTLE_CYCLES  = 4,
   parameter int MIX_CYCLES     = 16,
   parameter int CNT_W          = 8,
   parameter int TIMEOUT_CYCLES = 200
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic        pump_ack,
   output logic        busy,
   output logic        done,
   output logic [2:0]  stage,
   output logic        pump_req,
   output logic        ds_s_en,
   output logic [22:0] ds_b_en,
   output logic [7:0]  ds_r_en,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_OPEN  = 3'd1,
      S_PUMP  = 3'd2,
      S_CLOSE = 3'd3,
      S_MIX   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] MIX_LAST    = CNT_W'(MIX_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
`ifdef PROTEIN_SEQ_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

   generate
      if (SETTLE_CYCLES < 1 || MIX_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
          (CNT_W < 31 && ((2 ** CNT_W) - 1) < SETTLE_CYCLES) ||
          (CNT_W < 31 && ((2 ** CNT_W) - 1) < MIX_CYCLES) ||
          (CNT_W < 31 && ((2 ** CNT_W) - 1) < TIMEOUT_CYCLES)) begin : g_bad_params
         $error("protein_assay_dispense_seq: illegal parameter combination");
      end
   endgenerate

   state_t            state_q, state_d;
   logic [2:0]        stage_q, stage_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pump_req_q, pump_req_d;
   logic              ds_s_q, ds_s_d;
   logic [22:0]       ds_b_q, ds_b_d;
   logic [7:0]        ds_r_q, ds_r_d;
   logic              err_q, err_d;

   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            stage_d = 3'd0;
            cnt_d   = '0;
            if (start && !abort) begin
               state_d = S_OPEN;
               err_d   = 1'b0;
            end
         end
         S_OPEN: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = S_PUMP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_PUMP: begin
            if (pump_ack) begin
               state_d = S_CLOSE;
               cnt_d   = '0;
            end
`ifdef PROTEIN_SEQ_TIMEOUT_EN
            else if (cnt_q == TIMEOUT_LAST) begin
               state_d = S_IDLE;
               stage_d = 3'd0;
               cnt_d   = '0;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
`endif
         end
         S_CLOSE: begin
            state_d = S_MIX;
            cnt_d   = '0;
         end
         S_MIX: begin
            if (cnt_q == MIX_LAST) begin
               cnt_d = '0;
               if (stage_q == 3'd5) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_OPEN;
                  stage_d = stage_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            stage_d = 3'd0;
         end
         default: begin
            state_d = S_IDLE;
            stage_d = 3'd0;
            cnt_d   = '0;
         end
      endcase

      // Abort overrides everything, including a same-cycle ack or watchdog trip.
      if (abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
         stage_d = 3'd0;
         cnt_d   = '0;
         err_d   = err_q;
      end

      busy_d     = (state_d == S_OPEN) || (state_d == S_PUMP) ||
                   (state_d == S_CLOSE) || (state_d == S_MIX);
      done_d     = (state_d == S_DONE);
      pump_req_d = (state_d == S_PUMP);
      ds_s_d     = 1'b0;
      ds_b_d     = '0;
      ds_r_d     = '0;
      if (state_d == S_OPEN || state_d == S_PUMP) begin
         case (stage_d)
            3'd0: begin
               ds_s_d = 1'b1;
               ds_b_d = 23'h000001;
            end
            3'd1:    ds_b_d = 23'h000006;
            3'd2:    ds_b_d = 23'h000078;
            3'd3:    ds_b_d = 23'h007F80;
            3'd4:    ds_b_d = 23'h7F8000;
            3'd5:    ds_r_d = 8'hFF;
            default: ds_b_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         stage_q    <= 3'd0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pump_req_q <= 1'b0;
         ds_s_q     <= 1'b0;
         ds_b_q     <= '0;
         ds_r_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         stage_q    <= stage_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pump_req_q <= pump_req_d;
         ds_s_q     <= ds_s_d;
         ds_b_q     <= ds_b_d;
         ds_r_q     <= ds_r_d;
         err_q      <= err_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign stage    = stage_q;
   assign pump_req = pump_req_q;
   assign ds_s_en  = ds_s_q;
   assign ds_b_en  = ds_b_q;
   assign ds_r_en  = ds_r_q;
   assign err      = err_q;

endmodule
`default_nettype wire

// File: doc/protein_assay_dispense_seq.md
Name: protein_assay_dispense_seq

Overview:
Sequencer that drives the dispense valves feeding the 62-node ProteinSplit dilution/mix network. It walks the network layer by layer:
- sample + first buffer
- C/2, C/4, C/8 and C/16 buffer layers
- final reagent layer

For each layer it opens the matching valve group, handshakes with the shared pump controller, then waits for on-chip mixing. It sits between the host assay controller (start/done) and the valve/pump driver board.

Parameters:
SETTLE_CYCLES, 4, cycles valves held open before pump request (valve settle), min 1
MIX_CYCLES, 16, cycles waited after valves close before next layer, min 1
CNT_W, 8, width of internal cycle counter; must hold max(SETTLE_CYCLES, MIX_CYCLES, TIMEOUT_CYCLES)
TIMEOUT_CYCLES, 200, pump-ack watchdog limit (used only with optional feature)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins run when idle
abort  input  1  level; forces safe shutdown
pump_ack  input  1  one-cycle pulse from pump controller: volume delivered
busy  output  1  high from accepted start until done/abort completes
done  output  1  one-cycle pulse when final layer mix wait ends
stage  output  3  current layer index 0..5 (0 when idle)
pump_req  output  1  request pump stroke for open valve group
ds_s_en  output  1  valve enable, sample DsS
ds_b_en  output  23  valve enables DsB1..DsB23 (bit0 = DsB1)
ds_r_en  output  8  valve enables DsR1..DsR8 (bit0 = DsR1)
err  output  1  sticky watchdog error (optional feature)

Behaviour:
- Reset (async, rst_n low): state IDLE, all valve enables 0, pump_req 0, busy 0, done 0, stage 0, err 0, counter 0.
- Layer valve masks (registered outputs, asserted only in OPEN/PUMP):
  - L0 = DsS + DsB1
  - L1 = DsB2-3
  - L2 = DsB4-7
  - L3 = DsB8-15
  - L4 = DsB16-23
  - L5 = DsR1-8
- FSM states: IDLE, OPEN, PUMP, CLOSE, MIX, DONE.
- IDLE: start=1 -> OPEN, stage 0, busy 1. A start while busy is ignored.
- OPEN: mask for current stage asserted, counter counts up. After SETTLE_CYCLES cycles in OPEN -> PUMP.
- PUMP: mask held, pump_req 1 until the cycle pump_ack is sampled high -> CLOSE. pump_req drops in the next cycle. pump_ack outside PUMP is ignored.
- CLOSE: one cycle, all valves 0, pump_req 0 -> MIX, counter cleared.
- MIX: after MIX_CYCLES cycles:
  - stage<5 -> stage+1, OPEN
  - stage==5 -> DONE
- DONE: done=1 for exactly one cycle, busy 0 in that cycle -> IDLE, stage 0.
- Latency, start to done = 6*(SETTLE_CYCLES + P + 1 + MIX_CYCLES) + 1, where P = cycles of pump wait, each >=1.
- Abort, any non-IDLE state: next cycle all valves 0, pump_req 0, go to IDLE, busy 0, no done pulse. Abort in IDLE has no effect. Abort wins over a simultaneous pump_ack or start.
- Invariant: at most one layer mask is ever non-zero. Valves never change in the same cycle pump_req rises.
- Counter saturates, never wraps.

Optional Feature:
Macro PROTEIN_SEQ_TIMEOUT_EN.
- Defined:
  - Counter runs in PUMP.
  - If TIMEOUT_CYCLES elapse without pump_ack: err set (sticky until reset or next accepted start), shutdown identical to abort, no done pulse.
- Undefined:
  - PUMP waits indefinitely.
  - err tied 0.
  - TIMEOUT_CYCLES unused.

Test Plan:
- Reset mid-run (rst_n low during L3 PUMP) -> all outputs 0 immediately, no done; a later start runs from stage 0.
- Nominal run, defaults, pump_ack 2 cycles after each pump_req rise -> masks in order: 0x1/ds_s, ds_b 0x000006, 0x000078, 0x007F80, 0x7F8000, then ds_r 0xFF; done one pulse at cycle 6*(4+2+1+16)+1=139 after start.
- Abort during L2 MIX -> next cycle busy 0, stage 0, valves 0, no done; pump_ack pulses afterward produce no change.
- Start pulse while busy and pump_ack pulse in OPEN -> both ignored; sequence timing unchanged vs. nominal.
- Abort and pump_ack same cycle in L4 PUMP -> IDLE, no CLOSE/MIX, no done.
- PROTEIN_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=200, pump_ack withheld at L1 -> err=1 after 200 PUMP cycles, valves 0, busy 0. New start clears err, run completes normally.
